// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data port has priority over instruction fetch, reads wait MEM_LAT cycles.
// Optional macro ARB_STARVE_GUARD_EN lets a starved fetch win after STARVE_MAX consecutive denials.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        latCnt_q, latCnt_d;
    logic              ownerData_q, ownerData_d;
    logic [DATA_W-1:0] ifRdata_q, dRdata_q;
    logic              ifRvalid_q, dRvalid_q;
    logic              fetchWin, dataWin, capture, starveHit;

    if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_MAX < 1) begin : g_badParams
        $error("mem_arbiter: MEM_LAT must be 1..4 and STARVE_MAX at least 1");
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q, starve_d;

    assign starveHit = (starve_q == SW'(STARVE_MAX));

    // Count consecutive arbitration losses of a waiting fetch; saturates at STARVE_MAX.
    always_comb begin
        starve_d = starve_q;
        if (!if_req || fetchWin) begin
            starve_d = '0;
        end else if (state_q == IDLE && !starveHit) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starveHit = 1'b0;
`endif

    // Outputs are forced quiet while reset is held, even though the state is already IDLE.
    always_comb begin
        state_d     = state_q;
        latCnt_d    = latCnt_q;
        ownerData_d = ownerData_q;
        fetchWin    = 1'b0;
        dataWin     = 1'b0;
        capture     = 1'b0;
        busy        = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (if_req && (!d_req || starveHit)) begin
                        fetchWin = 1'b1;
                    end else if (d_req) begin
                        dataWin = 1'b1;
                    end
                    if (dataWin) begin
                        mem_en    = 1'b1;
                        mem_we    = d_we;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata;
                    end else if (fetchWin) begin
                        mem_en   = 1'b1;
                        mem_addr = if_addr;
                    end
                    if (fetchWin || (dataWin && !d_we)) begin
                        state_d     = RD_WAIT;
                        latCnt_d    = 3'(MEM_LAT);
                        ownerData_d = dataWin;
                    end
                end
                RD_WAIT: begin
                    busy     = 1'b1;
                    latCnt_d = latCnt_q - 3'd1;
                    if (latCnt_q == 3'd1) begin
                        capture = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            latCnt_q    <= '0;
            ownerData_q <= 1'b0;
            ifRdata_q   <= '0;
            dRdata_q    <= '0;
            ifRvalid_q  <= 1'b0;
            dRvalid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            latCnt_q    <= latCnt_d;
            ownerData_q <= ownerData_d;
            ifRvalid_q  <= capture && !ownerData_q;
            dRvalid_q   <= capture && ownerData_q;
            if (capture && !ownerData_q) begin
                ifRdata_q <= mem_q;
            end
            if (capture && ownerData_q) begin
                dRdata_q <= mem_q;
            end
        end
    end

    assign if_gnt    = fetchWin;
    assign d_gnt     = dataWin;
    assign if_rvalid = ifRvalid_q;
    assign d_rvalid  = dRvalid_q;
    assign if_rdata  = ifRdata_q;
    assign d_rdata   = dRdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios then random traffic, checked against a transaction-level model.
module tb_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 3;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_q;
    logic [AW-1:0] mem_addr;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [DW-1:0] ram [256];
    logic [DW-1:0] pipe [LAT];
    logic          loadRam;

    logic [DW-1:0] refMem [256];
    int            freeCycle, rvCycle, starve;
    bit            rvPend, rvToData, gotIf, gotD;
    logic [DW-1:0] rvData, expIfRdata, expDRdata;
    logic          lastIfGnt, lastDGnt, lastBusy;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_q(mem_q), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] initVal(int i);
        if (i == 'h10) return 32'hDEADBEEF;
        if (i == 'h30) return 32'h12345678;
        return 32'(i) * 32'h9E3779B9 ^ 32'h0F0F5A5A;
    endfunction

    // Synchronous RAM with a LAT-deep read pipeline behind the arbiter.
    always @(posedge clk) begin
        if (loadRam) begin
            for (int i = 0; i < 256; i++) ram[i] <= initVal(i);
        end else if (mem_en && mem_we) begin
            ram[mem_addr[7:0]] <= mem_wdata;
        end
        pipe[0] <= ram[mem_addr[7:0]];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_q = pipe[LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Sample one cycle at the falling edge, compare against the model, then advance the model.
    task automatic checkOutput();
        bit idle, rvNow, fWin, dWin;
        logic [AW-1:0] expAddr;
        @(negedge clk);
        lastIfGnt = if_gnt;
        lastDGnt  = d_gnt;
        lastBusy  = busy;
        if (rst) begin
            freeCycle = 0; rvPend = 0; starve = 0; gotIf = 0; gotD = 0;
            expIfRdata = '0; expDRdata = '0;
            check("rst if_gnt", if_gnt, 0);
            check("rst d_gnt", d_gnt, 0);
            check("rst mem_en", mem_en, 0);
            check("rst mem_we", mem_we, 0);
            check("rst busy", busy, 0);
            check("rst if_rvalid", if_rvalid, 0);
            check("rst d_rvalid", d_rvalid, 0);
            check("rst mem_addr", mem_addr, 0);
            check("rst mem_wdata", mem_wdata, 0);
            check("rst if_rdata", if_rdata, 0);
            check("rst d_rdata", d_rdata, 0);
        end else begin
            idle  = (cyc >= freeCycle);
            rvNow = rvPend && (cyc == rvCycle);
            if (rvNow) begin
                if (rvToData) expDRdata = rvData;
                else expIfRdata = rvData;
                rvPend = 0;
            end
`ifdef ARB_STARVE_GUARD_EN
            fWin = idle && if_req && (!d_req || starve == SMAX);
`else
            fWin = idle && if_req && !d_req;
`endif
            dWin = idle && d_req && !fWin;
            expAddr = dWin ? d_addr : (fWin ? if_addr : '0);
            check("if_gnt", if_gnt, fWin);
            check("d_gnt", d_gnt, dWin);
            check("busy", busy, !idle);
            check("mem_en", mem_en, fWin || dWin);
            check("mem_we", mem_we, dWin && d_we);
            if (idle) check("mem_addr", mem_addr, expAddr);
            if (dWin || (idle && !fWin)) check("mem_wdata", mem_wdata, dWin ? d_wdata : '0);
            check("if_rvalid", if_rvalid, rvNow && !rvToData);
            check("d_rvalid", d_rvalid, rvNow && rvToData);
            check("if_rdata", if_rdata, expIfRdata);
            check("d_rdata", d_rdata, expDRdata);
            if (dWin && d_we) refMem[d_addr[7:0]] = d_wdata;
            if (fWin || (dWin && !d_we)) begin
                freeCycle = cyc + LAT + 1;
                rvCycle   = cyc + LAT + 1;
                rvPend    = 1;
                rvToData  = dWin;
                rvData    = refMem[expAddr[7:0]];
            end
            if (!if_req || fWin) starve = 0;
            else if (idle && starve < SMAX) starve++;
            gotIf = fWin;
            gotD  = dWin;
        end
        cyc++;
    endtask

    // Advance to just after the next rising edge and retire any request that was just granted.
    task automatic applyStimulus();
        checkOutput();
        @(posedge clk);
        #1;
        if (gotIf) if_req = 1'b0;
        if (gotD) d_req = 1'b0;
    endtask

    task automatic randomReqs();
        if (if_req && $urandom_range(0, 15) == 0) if_req = 1'b0;
        else if (!if_req && $urandom_range(0, 2) != 0) begin
            if_req  = 1'b1;
            if_addr = AW'($urandom_range(0, 255));
        end
        if (d_req && $urandom_range(0, 15) == 0) d_req = 1'b0;
        else if (!d_req && $urandom_range(0, 2) != 0) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = AW'($urandom_range(0, 255));
            d_wdata = $urandom;
        end
    endtask

    initial begin
        int firstIfGnt, busyCnt;
        rst = 1'b1; loadRam = 1'b1;
        if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 256; i++) refMem[i] = initVal(i);
        @(posedge clk);
        #1;
        loadRam = 1'b0;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;

        // Fetch read of a preloaded word.
        if_req = 1; if_addr = 'h10;
        repeat (LAT + 2) applyStimulus();
        check("t1 if_rdata", if_rdata, 32'hDEADBEEF);

        // Simultaneous requests: data read wins, fetch follows on completion.
        if_req = 1; if_addr = 'h40;
        d_req = 1; d_we = 0; d_addr = 'h30;
        repeat (2 * LAT + 4) applyStimulus();
        check("t2 d_rdata", d_rdata, 32'h12345678);

        // Write then fetch the same word.
        d_req = 1; d_we = 1; d_addr = 'h20; d_wdata = 'h5;
        applyStimulus();
        if_req = 1; if_addr = 'h20;
        repeat (LAT + 2) applyStimulus();
        check("t3 if_rdata", if_rdata, 32'h5);

        // Held writes against a held fetch.
        if_req = 1; if_addr = 'h11;
        d_req = 1; d_we = 1; d_addr = 'h80; d_wdata = $urandom;
        firstIfGnt = -1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus();
            if (lastIfGnt === 1'b1 && firstIfGnt < 0) firstIfGnt = k;
            if (!d_req) begin
                d_req = 1; d_we = 1; d_addr = AW'('h81 + k); d_wdata = $urandom;
            end
        end
`ifdef ARB_STARVE_GUARD_EN
        check("t4 starve grant idx", firstIfGnt, 4);
`else
        check("t4 starve grant idx", firstIfGnt, -1);
`endif
        d_req = 0;
        repeat (LAT + 3) applyStimulus();

        // Reset in the middle of a read.
        if_req = 1; if_addr = 'h12;
        applyStimulus();
        applyStimulus();
        rst = 1;
        applyStimulus();
        rst = 0; if_req = 1; if_addr = 'h13;
        applyStimulus();
        check("t5 gnt after rst", lastIfGnt, 1);
        repeat (LAT + 2) applyStimulus();

        // Data read, then a write queued behind it.
        d_req = 1; d_we = 0; d_addr = 'h31;
        applyStimulus();
        d_req = 1; d_we = 1; d_addr = 'h32; d_wdata = 'hCAFE;
        busyCnt = 0;
        for (int k = 1; k <= LAT + 1; k++) begin
            applyStimulus();
            busyCnt += int'(lastBusy);
        end
        check("t6 busy cycles", busyCnt, LAT);
        check("t6 write gnt", lastDGnt, 1);

        // Random traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            randomReqs();
            if ($urandom_range(0, 63) == 0) rst = 1;
            applyStimulus();
            rst = 0;
        end
        if_req = 0; d_req = 0;
        repeat (LAT + 3) applyStimulus();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
